// File: rtl/tqvp_spike_array.sv
// tqvp_spike_array: NCH-channel temporal-difference spike detector on the TinyQV peripheral bus.
// Optional per-channel adaptive threshold offset is enabled by defining SPIKE_ARRAY_ADAPT_EN.
module tqvp_spike_array #(
  parameter int NCH            = 4,
  parameter int CNT_W          = 8,
  parameter int THRESH_DEFAULT = 20,
  parameter int REFRAC_DEFAULT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0] thr_reg;
  logic [2:0] ctrl_reg;
  logic [3:0] refrac_reg;

  logic       wr_thr, wr_ctrl, wr_refrac;
  logic [7:0] thr_cur, base_thr;
  logic [1:0] mode_cur;
  logic [3:0] refrac_cur;

  logic [3:0] pulse_vec, flag_vec, pol_vec;
  logic [7:0] pixel_arr  [4];
  logic [7:0] count_arr  [4];
  logic [3:0] offset_arr [4];

  assign wr_thr    = data_write && (address == 4'd4);
  assign wr_ctrl   = data_write && (address == 4'd5);
  assign wr_refrac = data_write && (address == 4'd6);

  // A config write lands on the same edge as any pending evaluation, so bypass it in.
  assign thr_cur    = wr_thr ? data_in : thr_reg;
  assign mode_cur   = wr_ctrl ? data_in[1:0] : ctrl_reg[1:0];
  assign refrac_cur = wr_refrac ? data_in[3:0] : refrac_reg;
  assign base_thr   = (thr_cur == 8'd0) ? 8'd1 : thr_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_reg    <= 8'(THRESH_DEFAULT);
      ctrl_reg   <= 3'd0;
      refrac_reg <= 4'(REFRAC_DEFAULT);
    end else begin
      if (wr_thr)    thr_reg    <= data_in;
      if (wr_ctrl)   ctrl_reg   <= data_in[2:0];
      if (wr_refrac) refrac_reg <= data_in[3:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : ch_g
      if (gi < NCH) begin : act_g
        logic [7:0]       pixel_reg, prev_reg, load_val;
        logic             sample_v_reg, primed_reg, pulse_reg, flag_reg, pol_reg;
        logic [CNT_W-1:0] count_reg;
        logic [3:0]       refc_reg;
        logic             wr_pix, stream_ld, load, eval, on_c, off_c, cand, spike;
        logic             clr_flag, clr_cnt;
        logic [8:0]       diff, mag, thr_eff;

        assign wr_pix    = data_write && (address == 4'(gi));
        assign stream_ld = (gi == 0) && ctrl_reg[2];
        assign load      = wr_pix || stream_ld;
        assign load_val  = wr_pix ? data_in : ui_in;
        assign clr_flag  = data_write && (address == 4'd7) && data_in[gi];
        assign clr_cnt   = data_write && (address == 4'(8 + gi));

        assign diff  = {1'b0, pixel_reg} - {1'b0, prev_reg};
        assign mag   = diff[8] ? (9'd0 - diff) : diff;
        assign on_c  = !diff[8] && (diff != 9'd0) && (mag >= thr_eff);
        assign off_c = diff[8] && (mag >= thr_eff);
        // mode 00 both, 01 ON only, 10 OFF only, 11 neither
        assign cand  = (on_c && !mode_cur[1]) || (off_c && !mode_cur[0]);
        assign eval  = sample_v_reg && primed_reg;
        assign spike = eval && cand && (refc_reg == 4'd0);

`ifdef SPIKE_ARRAY_ADAPT_EN
        logic [3:0] offset_reg;
        logic [8:0] thr_sum;
        assign thr_sum = {1'b0, base_thr} + {5'd0, offset_reg};
        assign thr_eff = (thr_sum > 9'd255) ? 9'd255 : thr_sum;
        assign offset_arr[gi] = offset_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            offset_reg <= 4'd0;
          end else if (spike) begin
            if (offset_reg != 4'd15) offset_reg <= offset_reg + 4'd1;
          end else if (eval && (offset_reg != 4'd0)) begin
            offset_reg <= offset_reg - 4'd1;
          end
        end
`else
        assign thr_eff = {1'b0, base_thr};
        assign offset_arr[gi] = 4'd0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            pixel_reg    <= 8'd0;
            prev_reg     <= 8'd0;
            sample_v_reg <= 1'b0;
            primed_reg   <= 1'b0;
            pulse_reg    <= 1'b0;
            flag_reg     <= 1'b0;
            pol_reg      <= 1'b0;
            count_reg    <= '0;
            refc_reg     <= 4'd0;
          end else begin
            pulse_reg    <= spike;
            sample_v_reg <= load;
            if (load) pixel_reg <= load_val;
            if (sample_v_reg) begin
              prev_reg   <= pixel_reg;
              primed_reg <= 1'b1;
            end
            if (eval && (refc_reg != 4'd0)) refc_reg <= refc_reg - 4'd1;
            else if (spike)                 refc_reg <= refrac_cur;
            if (spike) begin
              flag_reg <= 1'b1;
              pol_reg  <= on_c;
            end else if (clr_flag) begin
              flag_reg <= 1'b0;
            end
            if (clr_cnt)                               count_reg <= '0;
            else if (spike && (count_reg != CNT_MAX)) count_reg <= count_reg + CNT_W'(1);
          end
        end

        assign pulse_vec[gi] = pulse_reg;
        assign flag_vec[gi]  = flag_reg;
        assign pol_vec[gi]   = pol_reg;
        assign pixel_arr[gi] = pixel_reg;
        assign count_arr[gi] = 8'(count_reg);
      end else begin : pad_g
        assign pulse_vec[gi]  = 1'b0;
        assign flag_vec[gi]   = 1'b0;
        assign pol_vec[gi]    = 1'b0;
        assign pixel_arr[gi]  = 8'd0;
        assign count_arr[gi]  = 8'd0;
        assign offset_arr[gi] = 4'd0;
      end
    end
  endgenerate

  assign uo_out = {flag_vec, pulse_vec};

  always_comb begin
    data_out = 8'd0;
    case (address)
      4'd0, 4'd1, 4'd2, 4'd3:     data_out = pixel_arr[address[1:0]];
      4'd4:                       data_out = thr_reg;
      4'd5:                       data_out = {5'd0, ctrl_reg};
      4'd6:                       data_out = {4'd0, refrac_reg};
      4'd7:                       data_out = {4'd0, flag_vec};
      4'd8, 4'd9, 4'd10, 4'd11:   data_out = count_arr[address[1:0]];
      4'd12:                      data_out = {4'd0, pol_vec};
      4'd13:                      data_out = {offset_arr[1], offset_arr[0]};
      4'd14:                      data_out = {offset_arr[3], offset_arr[2]};
      default:                    data_out = 8'd0;
    endcase
  end
endmodule

// File: tb/tb_tqvp_spike_array.sv
// Scoreboard bench for tqvp_spike_array: a behavioural channel model pushes expected
// pulses/flags per sample, popped and compared when the DUT presents its output.
`timescale 1ns/1ps
module tb_tqvp_spike_array;
  localparam int NCH     = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uo_out;
  logic [3:0] address = 4'd0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  tqvp_spike_array #(.NCH(NCH), .CNT_W(CNT_W), .THRESH_DEFAULT(20), .REFRAC_DEFAULT(0)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Behavioural model state
  int         m_prev [4];
  int         m_cnt  [4];
  int         m_refc [4];
  int         m_off  [4];
  bit         m_primed [4];
  logic [3:0] m_flags, m_pol;
  int         m_thr, m_mode, m_refrac;

  typedef struct { logic [3:0] pulses; logic [3:0] flags; } exp_t;
  exp_t sb_q[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 0; m_cnt[i] = 0; m_refc[i] = 0; m_off[i] = 0; m_primed[i] = 0;
    end
    m_flags = 4'd0; m_pol = 4'd0;
    m_thr = 20; m_mode = 0; m_refrac = 0;
    sb_q.delete();
  endtask

  task automatic model_eval(input int ch, input int val, output bit sp);
    int d, mag, thr;
    bit on, off, cand;
    sp = 0;
    if (!m_primed[ch]) begin
      m_primed[ch] = 1;
      m_prev[ch] = val;
      return;
    end
    d   = val - m_prev[ch];
    mag = (d < 0) ? -d : d;
    thr = (m_thr == 0) ? 1 : m_thr;
`ifdef SPIKE_ARRAY_ADAPT_EN
    thr = thr + m_off[ch];
    if (thr > 255) thr = 255;
`endif
    on  = (d > 0) && (mag >= thr);
    off = (d < 0) && (mag >= thr);
    case (m_mode)
      0: cand = on || off;
      1: cand = on;
      2: cand = off;
      default: cand = 0;
    endcase
    if (m_refc[ch] != 0) m_refc[ch]--;
    else sp = cand;
    if (sp) begin
      m_flags[ch] = 1'b1;
      m_pol[ch]   = on;
      if (m_cnt[ch] < CNT_SAT) m_cnt[ch]++;
      m_refc[ch]  = m_refrac;
    end
`ifdef SPIKE_ARRAY_ADAPT_EN
    if (sp) begin
      if (m_off[ch] < 15) m_off[ch]++;
    end else if (m_off[ch] > 0) begin
      m_off[ch]--;
    end
`endif
    m_prev[ch] = val;
  endtask

  task automatic bus_write(input int addr, input int data);
    @(negedge clk);
    address = 4'(addr); data_in = 8'(data); data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus_write(addr, data);
    case (addr)
      4: m_thr = data & 255;
      5: m_mode = data & 3;
      6: m_refrac = data & 15;
      7: m_flags = m_flags & ~4'(data);
      default: ;
    endcase
  endtask

  task automatic check_reg(input string tag, input int addr, input int exp);
    address = 4'(addr); data_write = 1'b0;
    #1;
    check(tag, int'(data_out), exp);
  endtask

  task automatic pop_and_check(input int ch, input int val);
    exp_t e;
    e = sb_q.pop_front();
    $display("sample ch%0d val=%0d pulses=%b flags=%b", ch, val, uo_out[3:0], uo_out[7:4]);
    check($sformatf("pulse ch%0d", ch), int'(uo_out[3:0]), int'(e.pulses));
    check($sformatf("flags ch%0d", ch), int'(uo_out[7:4]), int'(e.flags));
  endtask

  task automatic push_exp(input int ch, input int val);
    exp_t e;
    bit sp;
    logic [3:0] one;
    one = 4'b0001;
    model_eval(ch, val, sp);
    e.pulses = sp ? (one << ch) : 4'd0;
    e.flags  = m_flags;
    sb_q.push_back(e);
  endtask

  task automatic send_sample(input int ch, input int val);
    push_exp(ch, val);
    bus_write(ch, val);
    @(negedge clk);
    pop_and_check(ch, val);
  endtask

  // Sample write followed by a second bus write landing on the evaluation edge.
  task automatic sample_with(input int ch, input int val, input int a2, input int d2);
    exp_t e;
    bit sp;
    logic [3:0] one;
    one = 4'b0001;
    model_eval(ch, val, sp);
    if (a2 == 7) begin
      m_flags = m_flags & ~4'(d2);
      if (sp) m_flags[ch] = 1'b1;
    end
    if (a2 == 8 + ch) m_cnt[ch] = 0;
    e.pulses = sp ? (one << ch) : 4'd0;
    e.flags  = m_flags;
    sb_q.push_back(e);
    @(negedge clk);
    address = 4'(ch); data_in = 8'(val); data_write = 1'b1;
    @(negedge clk);
    address = 4'(a2); data_in = 8'(d2);
    @(negedge clk);
    data_write = 1'b0;
    pop_and_check(ch, val);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    data_write = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int rst_exp [15] = '{0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int svals   [12] = '{30, 30, 30, 30, 60, 60, 60, 200, 60, 60, 60, 60};

  initial begin
    int pulses_seen, exp13;
    model_reset();
    reset_dut();

    // Reset state
    check("reset uo_out", int'(uo_out), 0);
    for (int a = 0; a < 15; a++) check_reg($sformatf("reset reg%0d", a), a, rst_exp[a]);
    bus_write(15, 255);
    check_reg("unmapped read", 15, 0);

    // Basic ON spike and one-cycle pulse
    send_sample(0, 10);
    send_sample(0, 40);
    @(negedge clk);
    check("pulse one cycle", int'(uo_out[0]), 0);
    check_reg("count0", 8, m_cnt[0]);
    check_reg("flag0", 7, 1);
    check_reg("pol0", 12, 1);

    // Polarity modes
    cfg_write(5, 1);
    send_sample(1, 100);
    send_sample(1, 50);
    cfg_write(5, 2);
    send_sample(1, 100);
    send_sample(1, 50);
    check_reg("pol after off", 12, int'(m_pol));
    check_reg("ctrl mode", 5, 2);
    cfg_write(5, 3);
    for (int ch = 0; ch < 4; ch++) begin
      send_sample(ch, 0);
      send_sample(ch, 255);
      send_sample(ch, 0);
    end
    cfg_write(5, 0);

    // Refractory period
    cfg_write(6, 2);
    cfg_write(4, 5);
    send_sample(2, 0);
    send_sample(2, 50);
    send_sample(2, 0);
    send_sample(2, 50);
    send_sample(2, 0);
    check_reg("count2 refrac", 10, 2);
    cfg_write(6, 0);
    cfg_write(4, 20);

    // Saturation and same-cycle clear/set
    for (int i = 0; i < 10; i++) send_sample(3, (i % 2 == 0) ? 200 : 0);
    check_reg("count3 sat", 11, CNT_SAT);
    sample_with(0, 100, 8, 0);
    check_reg("count0 clear wins", 8, 0);
    sample_with(0, 10, 7, 1);
    check_reg("flag0 set wins", 7, int'(m_flags));
    check("flag0 bit", int'(uo_out[4]), 1);

    // Stream mode with bus override on the same cycle
    reset_dut();
    ui_in = 8'd30;
    cfg_write(5, 4);
    pulses_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (sb_q.size() >= 2) begin
        if (uo_out[0]) pulses_seen++;
        pop_and_check(0, -1);
      end
      if (i == 7) begin
        address = 4'd0; data_in = 8'd200; data_write = 1'b1;
      end else begin
        data_write = 1'b0;
      end
      ui_in = 8'(i == 7 ? 60 : svals[i]);
      push_exp(0, svals[i]);
      @(negedge clk);
    end
    data_write = 1'b0;
    repeat (2) begin
      if (uo_out[0]) pulses_seen++;
      pop_and_check(0, -1);
      @(negedge clk);
    end
    check("stream pulses", pulses_seen, 3);
    check_reg("stream pixel0", 0, 60);
    cfg_write(5, 0);

    // Boundaries
    reset_dut();
    cfg_write(4, 0);
    send_sample(0, 7);
    send_sample(0, 7);
    send_sample(0, 8);
    cfg_write(4, 255);
    send_sample(1, 255);
    send_sample(1, 0);
    check_reg("pol 255->0", 12, int'(m_pol));
    check("pol1 off", int'(m_pol[1]), 0);

    // Reset between capture and evaluation
    cfg_write(4, 20);
    send_sample(1, 0);
    bus_write(1, 200);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset mid pulse", int'(uo_out), 0);
    rst_n = 1'b1;
    model_reset();
    check_reg("reset mid count1", 9, 0);
    send_sample(1, 200);
    send_sample(1, 0);

    // Adaptive offset readback
    reset_dut();
    send_sample(0, 0);
    send_sample(0, 100);
    send_sample(0, 0);
    send_sample(0, 100);
`ifdef SPIKE_ARRAY_ADAPT_EN
    exp13 = 3;
`else
    exp13 = 0;
`endif
    check_reg("offset addr13", 13, exp13);
    check_reg("offset addr14", 14, 0);
    check_reg("count0 final", 8, 3);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
